// File: rtl/epd_tx_arbiter.sv
// Two-source round-robin frame arbiter feeding the epd byte/control input.
// Define EPD_ARB_PREAMBLE_EN to have the arbiter emit the 8-byte preamble/SFD itself.
module epd_tx_arbiter #(
  parameter int IFG_MIN   = 1,
  parameter int MAX_FRAME = 1530,
  parameter int CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [7:0]       data0,
  input  logic             last0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [7:0]       data1,
  input  logic             last1,
  output logic             gnt1,
  output logic [7:0]       out_data,
  output logic             out_control,
  output logic             owner,
  output logic             busy,
  output logic             abort,
  output logic [CNT_W-1:0] frames_sent
);
  localparam int BW = $clog2(MAX_FRAME + 1);
  localparam int IW = $clog2(IFG_MIN + 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(MAX_FRAME - 1);
  localparam logic [IW-1:0] IFG_LAST  = IW'(IFG_MIN - 1);

  typedef enum logic [1:0] {IDLE, PRE, XFER, IFG} state_t;

  typedef struct packed {
    logic       req;
    logic       last;
    logic [7:0] data;
  } src_t;

  src_t [1:0] src;
  logic [1:0] gnt_v;

  assign src[0] = {req0, last0, data0};
  assign src[1] = {req1, last1, data1};

  state_t           state, state_n;
  logic             owner_n, rr_ptr, rr_n, ctrl_n, abort_n, win, any_req, launch;
  logic [7:0]       data_n;
  logic [CNT_W-1:0] fs_n;
  logic [BW-1:0]    byte_cnt, bc_n;
  logic [IW-1:0]    ifg_cnt, ic_n;
`ifdef EPD_ARB_PREAMBLE_EN
  logic [2:0]       pre_cnt, pre_n;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_gnt
    assign gnt_v[i] = (state == XFER) && (owner == 1'(i));
  end
  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];

`ifdef EPD_ARB_PREAMBLE_EN
  assign busy = (state == XFER) || (state == PRE);
`else
  assign busy = (state == XFER);
`endif

  // rr_ptr names the preferred source when both request
  assign any_req = src[0].req | src[1].req;
  assign win     = (src[0].req && src[1].req) ? rr_ptr : src[1].req;
  assign launch  = any_req && ((state == IDLE) || ((state == IFG) && (ifg_cnt == IFG_LAST)));

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    data_n  = 8'h00;
    ctrl_n  = 1'b0;
    abort_n = 1'b0;
    fs_n    = frames_sent;
    bc_n    = byte_cnt;
    ic_n    = ifg_cnt;
`ifdef EPD_ARB_PREAMBLE_EN
    pre_n   = pre_cnt;
`endif
    case (state)
`ifdef EPD_ARB_PREAMBLE_EN
      PRE: begin
        data_n = (pre_cnt == 3'd7) ? 8'hD5 : 8'h55;
        ctrl_n = 1'b1;
        pre_n  = pre_cnt + 3'd1;
        if (pre_cnt == 3'd7) state_n = XFER;
      end
`endif
      XFER: begin
        data_n = src[owner].data;
        ctrl_n = 1'b1;
        bc_n   = byte_cnt + 1'b1;
        // last wins over truncation when both land on the same byte
        if (src[owner].last) begin
          fs_n    = frames_sent + 1'b1;
          state_n = IFG;
          ic_n    = '0;
        end else if (byte_cnt == BYTE_LAST) begin
          abort_n = 1'b1;
          state_n = IFG;
          ic_n    = '0;
        end
      end
      IFG: begin
        ic_n = ifg_cnt + 1'b1;
        if (ifg_cnt == IFG_LAST) state_n = IDLE;
      end
      default: ;
    endcase
    if (launch) begin
      owner_n = win;
      rr_n    = ~win;
      bc_n    = '0;
`ifdef EPD_ARB_PREAMBLE_EN
      pre_n   = '0;
      state_n = PRE;
`else
      state_n = XFER;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      out_data    <= 8'h00;
      out_control <= 1'b0;
      abort       <= 1'b0;
      frames_sent <= '0;
      byte_cnt    <= '0;
      ifg_cnt     <= '0;
`ifdef EPD_ARB_PREAMBLE_EN
      pre_cnt     <= '0;
`endif
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      rr_ptr      <= rr_n;
      out_data    <= data_n;
      out_control <= ctrl_n;
      abort       <= abort_n;
      frames_sent <= fs_n;
      byte_cnt    <= bc_n;
      ifg_cnt     <= ic_n;
`ifdef EPD_ARB_PREAMBLE_EN
      pre_cnt     <= pre_n;
`endif
    end
  end
endmodule

// File: tb/tb_epd_tx_arbiter.sv
// Scoreboard bench for epd_tx_arbiter: source models feed queued frames, expected bytes are queued on grant.
module tb_epd_tx_arbiter;
  localparam int IFG_MIN   = 3;
  localparam int MAX_FRAME = 80;
  localparam int CNT_W     = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req0, last0, gnt0, req1, last1, gnt1;
  logic [7:0]       data0, data1, out_data;
  logic             out_control, owner, busy, abort;
  logic [CNT_W-1:0] frames_sent;

  epd_tx_arbiter #(.IFG_MIN(IFG_MIN), .MAX_FRAME(MAX_FRAME), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .data0(data0), .last0(last0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .last1(last1), .gnt1(gnt1),
    .out_data(out_data), .out_control(out_control), .owner(owner),
    .busy(busy), .abort(abort), .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       abrt;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] q0[$], q1[$];
  int         order_q[$];
  int         n_cmp = 0, n_bad = 0;
  logic [1:0] gnt_prev, flush;
  int         idx0, idx1, ctrl_cnt, gap, abort_cnt, cyc, first_gnt, first_ctrl;
  bit         prev_ctrl, seen_frame, check_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    if (s == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
  endtask

  task automatic drive();
    logic [8:0] b;
    req0 = (q0.size() != 0);
    b = req0 ? q0[0] : 9'h0;
    {last0, data0} = b;
    req1 = (q1.size() != 0);
    b = req1 ? q1[0] : 9'h0;
    {last1, data1} = b;
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete(); exp_q.delete(); order_q.delete();
    idx0 = 0; idx1 = 0; gnt_prev = '0; flush = '0;
    prev_ctrl = 0; seen_frame = 0; gap = 0; ctrl_cnt = 0; abort_cnt = 0;
    first_gnt = -1; first_ctrl = -1; check_gap = 0;
    drive();
  endtask

  // one byte taken at the coming rising edge
  task automatic take(input int s);
    logic [8:0] b;
    int         n;
    exp_t       e;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      chk("gnt_without_req", (s == 0) ? q0.size() : q1.size(), 1);
      return;
    end
    b = (s == 0) ? q0[0] : q1[0];
    n = (s == 0) ? idx0 : idx1;
    if (n == 0) begin
      order_q.push_back(s);
      if (first_gnt < 0) first_gnt = cyc;
    end
    n++;
    e.data = b[7:0];
    e.abrt = !b[8] && (n == MAX_FRAME);
    exp_q.push_back(e);
    flush[s] = e.abrt;
    if (b[8] || e.abrt) n = 0;
    if (s == 0) idx0 = n; else idx1 = n;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (out_control) begin
      ctrl_cnt++;
      if (first_ctrl < 0) first_ctrl = cyc;
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("abort", abort, e.abrt);
      end
      if (!prev_ctrl && seen_frame && check_gap) chk("ifg_gap", gap, IFG_MIN);
      seen_frame = 1;
      gap = 0;
    end else begin
      gap++;
      chk("abort_idle", abort, 1'b0);
    end
    prev_ctrl = out_control;
    if (abort) abort_cnt++;
    if (gnt_prev[0]) begin if (flush[0]) q0.delete(); else void'(q0.pop_front()); end
    if (gnt_prev[1]) begin if (flush[1]) q1.delete(); else void'(q1.pop_front()); end
    flush = '0;
    drive();
    if (gnt0) take(0);
    if (gnt1) take(1);
    gnt_prev = {gnt1, gnt0};
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !busy && !out_control)
           && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_clear();
    repeat (2) @(negedge clock);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_control", out_control, 1'b0);
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_abort", abort, 1'b0);
    chk("rst_frames_sent", frames_sent, 0);
    chk("rst_owner", owner, 1'b0);
    reset = 1'b1;

    // single 72-byte frame from source 0
    do_reset();
    for (int i = 0; i < 7; i++) push_byte(0, 8'h55, 0);
    push_byte(0, 8'hD5, 0);
    for (int i = 1; i <= 6; i++) push_byte(0, 8'(i), 0);
    for (int i = 0; i < 6; i++) push_byte(0, 8'(8'hFF - i), 0);
    push_byte(0, 8'h08, 0);
    push_byte(0, 8'h00, 0);
    for (int i = 0; i < 49; i++) push_byte(0, 8'h55, 0);
    push_byte(0, 8'h56, 1);
    drive();
    drain(300);
    chk("single_ctrl_cycles", ctrl_cnt, 72);
    chk("single_latency", first_ctrl - first_gnt, 1);
    chk("single_frames", frames_sent, 1);
    chk("single_owner", owner, 1'b0);

    // both sources held, three frames each
    do_reset();
    check_gap = 1;
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < 4 + k; i++) push_byte(s, 8'(s * 64 + k * 8 + i), i == 3 + k);
    drive();
    drain(300);
    chk("b2b_frames", frames_sent, 6);
    chk("b2b_order_len", order_q.size(), 6);
    for (int i = 0; i < order_q.size(); i++) chk("b2b_order", order_q[i], i % 2);

    // runaway frame on source 1, then a frame of exactly MAX_FRAME bytes with last on source 0
    do_reset();
    check_gap = 1;
    for (int i = 0; i < MAX_FRAME + 8; i++) push_byte(1, 8'(i + 3), 0);
    drive();
    repeat (5) tick();
    for (int i = 0; i < MAX_FRAME; i++) push_byte(0, 8'(200 - i), i == MAX_FRAME - 1);
    drive();
    drain(600);
    chk("trunc_frames", frames_sent, 1);
    chk("trunc_abort_pulses", abort_cnt, 1);
    chk("trunc_ctrl_cycles", ctrl_cnt, 2 * MAX_FRAME);
    chk("trunc_order_len", order_q.size(), 2);
    chk("trunc_first", order_q[0], 1);
    chk("trunc_second", order_q[1], 0);

    // reset asserted during byte 20 of a frame from source 1
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(1, 8'(i + 1), i == 4);
    for (int i = 0; i < 30; i++) push_byte(1, 8'(i + 100), i == 29);
    drive();
    begin
      int n = 0;
      while (!(idx1 == 20) && n < 200) begin tick(); n++; end
      chk("midrst_reach_byte20", n < 200, 1'b1);
    end
    chk("midrst_pre_frames", frames_sent, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_control", out_control, 1'b0);
    chk("midrst_out_data", out_data, 8'h00);
    chk("midrst_gnt", {gnt1, gnt0}, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_owner", owner, 1'b0);
    chk("midrst_frames", frames_sent, 0);
    model_clear();
    for (int i = 0; i < 30; i++) push_byte(1, 8'(i + 100), i == 29);
    drive();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drain(300);
    chk("midrst_regrant", order_q.size() == 1 && order_q[0] == 1, 1'b1);
    chk("midrst_post_frames", frames_sent, 1);
    chk("midrst_ctrl_cycles", ctrl_cnt, 30);

    // 17 back-to-back frames wrap the 4-bit counter
    do_reset();
    check_gap = 1;
    for (int f = 0; f < 17; f++)
      for (int i = 0; i < 3; i++) push_byte(0, 8'(f * 3 + i), i == 2);
    drive();
    drain(600);
    chk("wrap_frames", frames_sent, 1);
    chk("wrap_order_len", order_q.size(), 17);
    chk("wrap_ctrl_cycles", ctrl_cnt, 51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/epd_tx_arbiter.md
Name: epd_tx_arbiter

Overview:
- Round-robin arbiter and sequencer for the byte stream that feeds the Ethernet packet detector (epd).
- Two frame sources share the single data/control input of the epd. The arbiter grants one source for a whole frame, forwards its bytes with control=1, and enforces a minimum inter-frame gap (control=0, data=0x00).
- It also counts completed frames and truncates runaway frames.

Parameters:
IFG_MIN, 1, minimum idle cycles between frames on out_control; legal range >=1
MAX_FRAME, 1530, maximum source bytes per frame before forced truncation
CNT_W, 4, width of frames_sent

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  source 0 has a frame ready; held until its last byte is taken
data0  input  8  source 0 current byte
last0  input  1  source 0 current byte is the final byte of the frame
gnt0  output  1  source 0 byte sampled at this rising edge; source advances next cycle
req1  input  1  source 1 request
data1  input  8  source 1 byte
last1  input  1  source 1 last byte
gnt1  output  1  source 1 byte-taken strobe
out_data  output  8  byte to epd data input
out_control  output  1  to epd control input; 1 = frame byte, 0 = IFG/idle
owner  output  1  index of the source currently or most recently granted
busy  output  1  high in XFER (and PRE when the optional feature is enabled)
abort  output  1  one-cycle pulse when a frame is truncated at MAX_FRAME
frames_sent  output  CNT_W  count of frames ended by last; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, owner=0, out_data=0x00, out_control=0, gnt0=gnt1=0, busy=0, abort=0, frames_sent=0, byte_cnt=0, ifg_cnt=0. Reset asserted mid-frame kills the frame immediately; the frame is not counted.
- gntN is combinational: gntN = (state==XFER) && (owner==N). The source must present a valid byte every granted cycle; there are no bubbles.
- Output latency: out_data/out_control are registered. A byte sampled at edge k appears on out_data with out_control=1 during the cycle after edge k.
- Arbitration, used in IDLE and on the last IFG cycle:
  - Only one req high: that source wins.
  - Both high: the source != rr_ptr-last-served wins (rr_ptr holds the preferred index; after a grant, rr_ptr = ~winner).
  - After reset with both requesting, source 0 wins.
- States:
  - IDLE: out_control<=0, out_data<=0x00. If any req, latch owner, byte_cnt=0, go to XFER.
  - XFER: out_data<=data_owner, out_control<=1, byte_cnt++.
    - last_owner=1: frames_sent++, go to IFG.
    - Else byte_cnt reaches MAX_FRAME (the MAX_FRAME-th byte sampled without last): abort pulses next cycle, go to IFG, frame not counted.
    - last and MAX_FRAME on the same byte: treated as a normal last.
  - IFG: out_control<=0, out_data<=0x00, ifg_cnt++.
    - On the IFG_MIN-th IFG cycle: if a req is present, arbitrate and go directly to XFER; else go to IDLE.
    - Back-to-back frames therefore have exactly IFG_MIN control=0 cycles between them.
- req deasserted while owner is in XFER: protocol violation; the arbiter continues sampling until last or MAX_FRAME.
- byte_cnt width is $clog2(MAX_FRAME+1); ifg_cnt width is $clog2(IFG_MIN+1).

Optional Feature:
- Macro: EPD_ARB_PREAMBLE_EN.
- Defined:
  - A PRE state is added between arbitration and XFER. It emits 7×0x55 then 0xD5 with out_control=1 over 8 cycles.
  - gnt stays low during PRE; busy is high.
  - Sources supply bytes from DST onward. MAX_FRAME counts source bytes only.
- Undefined: no PRE state; sources supply the preamble themselves.

Test Plan:
- Single frame: src0 sends 72 bytes (7×0x55, 0xD5, DST 01..06, SRC FF..FA, 08 00, 49×0x55, 0x56), last on 0x56 -> out_control high exactly 72 cycles, starting 1 cycle after the first gnt0; frames_sent=1; an epd downstream reports valid_packet_counter=1.
- Back-to-back: req0 and req1 both held, 3 frames each -> grant order 0,1,0,1,0,1; exactly IFG_MIN=1 control=0 cycle between frames; frames_sent=6.
- Truncation: MAX_FRAME=16, src1 sends 40 bytes with no last -> 16 forwarded bytes, abort pulse for 1 cycle, frames_sent unchanged, src0 served after the IFG.
- Reset mid-frame: reset=0 for 2 cycles during byte 20 -> all outputs 0 asynchronously; after release, the held req0 is re-granted and frames_sent restarts from 0.
- Wrap: 17 frames with CNT_W=4 -> frames_sent=1; IFG_MIN=4 -> 4 idle cycles between frames.
- EPD_ARB_PREAMBLE_EN defined: src0 sends 64 bytes starting at DST -> out_data shows 55×7, D5, then the source bytes; out_control high for 72 cycles; gnt0 first asserted 8 cycles after the grant decision.
